uart_tx_fifo: RTL and testbench

//  Byte FIFO and handshake sequencer that sits directly upstream of uart_tx.
//  A producer (message generator, CPU port) pushes bytes at any rate.
//  The block presents them one at a time to uart_tx using its
//  i_byte_in/i_data_valid/o_tx_active/o_tx_done protocol.
//  It replaces hand-written per-byte send state machines in top-level designs.

---
 rtl/uart_tx_fifo_if.sv | 26 ++
 rtl/uart_tx_fifo.sv | 116 +++++++++++
 tb/tb_uart_tx_fifo.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Producer-side and uart_tx-side signals of the byte FIFO / send sequencer.
// slave is the FIFO's view; master is the view of whatever drives the inputs.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      i_wr_data;
  logic            i_wr_en;
  logic            o_full;
  logic            o_empty;
  logic [ADDR_W:0] o_count;
  logic            o_overflow;
  logic [7:0]      o_byte;
  logic            o_data_valid;
  logic            i_tx_active;
  logic            i_tx_done;

  modport master (
    output i_wr_data, i_wr_en, i_tx_active, i_tx_done,
    input  o_full, o_empty, o_count, o_overflow, o_byte, o_data_valid
  );

  modport slave (
    input  i_wr_data, i_wr_en, i_tx_active, i_tx_done,
    output o_full, o_empty, o_count, o_overflow, o_byte, o_data_valid
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx one byte at a time through its
// valid/active/done handshake.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  uart_tx_fifo_if.slave bus
);
  typedef enum logic [1:0] {
    ST_DRAIN  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_LAUNCH = 2'd2,
    ST_SEND   = 2'd3
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_e              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q;
  logic [7:0]          byte_q;
  logic                data_valid_q;
  logic                full, empty, wr_ok, pop;
  logic [7:0]          mem_rd [DEPTH];

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  // Full is judged on the pre-edge count, so a pop in the same cycle
  // does not rescue a write into a full FIFO.
  assign wr_ok = bus.i_wr_en && !full;
  assign pop   = (state_q == ST_SEND) && bus.i_tx_done;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      logic [7:0] entry_q;
      always_ff @(posedge i_clk) begin
        if (wr_ok && (wr_ptr_q == ADDR_W'(gi))) begin
          entry_q <= bus.i_wr_data;
        end
      end
      assign mem_rd[gi] = entry_q;
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_W'(wr_ok);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
    count_d  = count_q + (ADDR_W + 1)'(wr_ok) - (ADDR_W + 1)'(pop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= bus.i_wr_en && full;
    end
  end

  // DRAIN waits out a byte or a stale done level left in uart_tx,
  // which keeps running across our reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_DRAIN;
      byte_q       <= 8'h00;
      data_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_DRAIN: begin
          data_valid_q <= 1'b0;
          if (!bus.i_tx_active && !bus.i_tx_done) begin
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (!empty) begin
            byte_q       <= mem_rd[rd_ptr_q];
            data_valid_q <= 1'b1;
            state_q      <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (bus.i_tx_active) begin
            data_valid_q <= 1'b0;
            state_q      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bus.i_tx_done) begin
            state_q <= ST_DRAIN;
          end
        end
        default: begin
          data_valid_q <= 1'b0;
          state_q      <= ST_DRAIN;
        end
      endcase
    end
  end

  assign bus.o_full       = full;
  assign bus.o_empty      = empty;
  assign bus.o_count      = count_q;
  assign bus.o_overflow   = overflow_q;
  assign bus.o_byte       = byte_q;
  assign bus.o_data_valid = data_valid_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Random and directed stimulus for uart_tx_fifo, checked every cycle against a
// queue-based model of the FIFO and its send handshake.
module tb_uart_tx_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst_n;

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: pending bytes (front = byte on offer / in flight) plus handshake flags.
  logic [7:0] mq [$];
  logic [7:0] acc [$];
  logic [7:0] sent [$];
  bit         m_offering, m_sending, m_quiet, e_ovf;
  logic [7:0] e_byte;
  int         max_cnt;
  bit         ovf_seen;

  // uart_tx stand-in (no reset, like the real one).
  bit mk_manual, mk_rand;
  int mk_len, mph, mcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_offering = 1'b0;
    m_sending  = 1'b0;
    m_quiet    = 1'b0;
    e_ovf      = 1'b0;
    e_byte     = 8'h00;
  endtask

  task automatic model_edge();
    bit full_pre;
    if (!rst_n) return;
    full_pre = (mq.size() == DEPTH);
    e_ovf = bus.i_wr_en && full_pre;
    if (m_sending) begin
      if (bus.i_tx_done) begin
        m_sending = 1'b0;
        m_quiet   = 1'b0;
        mq.delete(0);
      end
    end else if (m_offering) begin
      if (bus.i_tx_active) begin
        m_offering = 1'b0;
        m_sending  = 1'b1;
      end
    end else if (!m_quiet) begin
      if (!bus.i_tx_active && !bus.i_tx_done) m_quiet = 1'b1;
    end else if (mq.size() != 0) begin
      m_offering = 1'b1;
      e_byte     = mq[0];
    end
    if (bus.i_wr_en && !full_pre) begin
      mq.push_back(bus.i_wr_data);
      acc.push_back(bus.i_wr_data);
    end
  endtask

  task automatic check_model();
    chk("count",      32'(bus.o_count),      32'(mq.size()));
    chk("empty",      32'(bus.o_empty),      32'(mq.size() == 0));
    chk("full",       32'(bus.o_full),       32'(mq.size() == DEPTH));
    chk("overflow",   32'(bus.o_overflow),   32'(e_ovf));
    chk("data_valid", 32'(bus.o_data_valid), 32'(m_offering));
    chk("byte",       32'(bus.o_byte),       32'(e_byte));
    if (int'(bus.o_count) > max_cnt) max_cnt = int'(bus.o_count);
    if (bus.o_overflow === 1'b1) ovf_seen = 1'b1;
  endtask

  task automatic uart_drive();
    int len;
    if (mk_manual) return;
    len = mk_rand ? int'($urandom_range(1, 12)) : mk_len;
    case (mph)
      0: begin
        bus.i_tx_active = 1'b0;
        bus.i_tx_done   = 1'b0;
        if (bus.o_data_valid === 1'b1) begin
          sent.push_back(bus.o_byte);
          mcnt = mk_rand ? int'($urandom_range(0, 2)) : 0;
          if (mcnt == 0) begin
            mph = 2; bus.i_tx_active = 1'b1; mcnt = len;
          end else begin
            mph = 1;
          end
        end
      end
      1: begin
        mcnt--;
        if (mcnt == 0) begin
          mph = 2; bus.i_tx_active = 1'b1; mcnt = len;
        end
      end
      2: begin
        mcnt--;
        if (mcnt == 0) begin
          bus.i_tx_active = 1'b0;
          bus.i_tx_done   = 1'b1;
          mph  = 3;
          mcnt = mk_rand ? int'($urandom_range(1, 2)) : 1;
        end
      end
      default: begin
        mcnt--;
        if (mcnt == 0) begin
          bus.i_tx_done = 1'b0;
          mph = 0;
        end
      end
    endcase
  endtask

  // One clock: model follows the edge, outputs are checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
    uart_drive();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_count", 32'(bus.o_count), 32'd0);
    chk("rst_empty", 32'(bus.o_empty), 32'd1);
    chk("rst_dv",    32'(bus.o_data_valid), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    string msg;
    int    dens;
    int    guard;
    logic [7:0] last_b;

    rst_n = 1'b1;
    bus.i_wr_en = 1'b0;
    bus.i_wr_data = 8'h00;
    bus.i_tx_active = 1'b0;
    bus.i_tx_done = 1'b0;
    mk_manual = 1'b0; mk_rand = 1'b0; mk_len = 4; mph = 0; mcnt = 0;
    max_cnt = 0; ovf_seen = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset, then a single byte: launch two edges after the write.
    apply_reset();
    sent.delete();
    bus.i_wr_en = 1'b1; bus.i_wr_data = 8'h48;
    tick();
    bus.i_wr_en = 1'b0;
    chk("h_dv_edge1",    32'(bus.o_data_valid), 32'd0);
    chk("h_count_edge1", 32'(bus.o_count), 32'd1);
    tick();
    chk("h_dv_edge2",    32'(bus.o_data_valid), 32'd1);
    chk("h_byte_edge2",  32'(bus.o_byte), 32'h48);
    tick();
    chk("h_dv_drop",     32'(bus.o_data_valid), 32'd0);
    chk("h_count_send",  32'(bus.o_count), 32'd1);
    repeat (3) tick();
    chk("h_count_predone", 32'(bus.o_count), 32'd1);
    tick();
    chk("h_count_done",  32'(bus.o_count), 32'd0);
    chk("h_sent",        32'(sent.size() == 1 && sent[0] == 8'h48), 32'd1);

    // Burst of 13 bytes with a 30-cycle character time.
    apply_reset();
    sent.delete(); acc.delete();
    max_cnt = 0; ovf_seen = 1'b0; mk_len = 30;
    msg = "Hello World!\n";
    for (int i = 0; i < msg.len(); i++) begin
      bus.i_wr_en = 1'b1; bus.i_wr_data = msg[i];
      tick();
    end
    bus.i_wr_en = 1'b0;
    guard = 0;
    while (!(mq.size() == 0 && mph == 0 && sent.size() == 13) && guard < 2000) begin
      tick(); guard++;
    end
    chk("hello_timeout", 32'(guard < 2000), 32'd1);
    chk("hello_nbytes",  32'(sent.size()), 32'd13);
    for (int i = 0; i < 13 && i < sent.size(); i++) chk("hello_byte", 32'(sent[i]), 32'(msg[i]));
    chk("hello_maxcnt",  32'(max_cnt), 32'd13);
    chk("hello_noovf",   32'(ovf_seen), 32'd0);

    // Stalled transmitter: fill to 16, 17th write overflows.
    apply_reset();
    mk_manual = 1'b1;
    bus.i_tx_active = 1'b1; bus.i_tx_done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.i_wr_en = 1'b1; bus.i_wr_data = 8'($urandom);
      tick();
    end
    chk("stall_full",  32'(bus.o_full), 32'd1);
    chk("stall_count", 32'(bus.o_count), 32'd16);
    chk("stall_dv",    32'(bus.o_data_valid), 32'd0);
    bus.i_wr_data = 8'hEE;
    tick();
    bus.i_wr_en = 1'b0;
    chk("ovf_pulse",  32'(bus.o_overflow), 32'd1);
    chk("ovf_count",  32'(bus.o_count), 32'd16);
    tick();
    chk("ovf_clear",  32'(bus.o_overflow), 32'd0);

    // Full FIFO in SEND: write and done together -> write dropped, count 15.
    bus.i_tx_active = 1'b0;
    tick();
    tick();
    chk("full_launch_dv", 32'(bus.o_data_valid), 32'd1);
    bus.i_tx_active = 1'b1;
    tick();
    bus.i_tx_active = 1'b0; bus.i_tx_done = 1'b1;
    bus.i_wr_en = 1'b1; bus.i_wr_data = 8'h77;
    tick();
    chk("full_pop_ovf",   32'(bus.o_overflow), 32'd1);
    chk("full_pop_count", 32'(bus.o_count), 32'd15);
    bus.i_wr_en = 1'b0; bus.i_tx_done = 1'b0;
    tick();
    mk_manual = 1'b0; mph = 0;

    // Reset while uart_tx is mid-byte with bytes queued.
    apply_reset();
    sent.delete();
    mk_len = 40;
    for (int i = 0; i < 6; i++) begin
      bus.i_wr_en = 1'b1; bus.i_wr_data = 8'(8'h30 + i);
      tick();
    end
    bus.i_wr_en = 1'b0;
    repeat (4) tick();
    chk("mid_active", 32'(bus.i_tx_active), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_count", 32'(bus.o_count), 32'd0);
    chk("mid_rst_dv",    32'(bus.o_data_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.i_wr_en = 1'b1; bus.i_wr_data = 8'hA5;
    tick();
    bus.i_wr_en = 1'b0;
    guard = 0;
    while (mph != 0 && guard < 200) begin
      chk("mid_no_launch", 32'(bus.o_data_valid), 32'd0);
      tick(); guard++;
    end
    chk("mid_drain_timeout", 32'(guard < 200), 32'd1);
    guard = 0;
    while (sent.size() < 2 && guard < 50) begin
      tick(); guard++;
    end
    last_b = (sent.size() >= 2) ? sent[sent.size() - 1] : 8'h00;
    chk("mid_next_byte", 32'(last_b), 32'hA5);
    chk("mid_nbytes",    32'(sent.size()), 32'd2);
    guard = 0;
    while (mph != 0 && guard < 200) begin
      tick(); guard++;
    end

    // Random traffic with varying write density and uart timing.
    apply_reset();
    sent.delete(); acc.delete();
    mk_rand = 1'b1;
    dens = 50;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) dens = int'($urandom_range(5, 95));
      bus.i_wr_en   = ($urandom_range(0, 99) < dens);
      bus.i_wr_data = 8'($urandom);
      tick();
    end
    bus.i_wr_en = 1'b0;
    guard = 0;
    while (!(mq.size() == 0 && mph == 0 && !m_offering) && guard < 3000) begin
      tick(); guard++;
    end
    chk("rand_drain_timeout", 32'(guard < 3000), 32'd1);
    chk("rand_nbytes", 32'(sent.size()), 32'(acc.size()));
    for (int i = 0; i < sent.size() && i < acc.size(); i++) chk("rand_order", 32'(sent[i]), 32'(acc[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
